data_table_dispatcher: RTL and testbench

- Front-end controller for the data table.
- Accepts hash-table tasks (ht_pdata_t) and routes each one by opcode to exactly one of three engines: 0 = search, 1 = insert, 2 = delete.
- Owns the single data-RAM port pair and muxes it to the engine currently holding the grant.
- Returns that engine's ht_result_t upstream. Exactly one task is in flight at a time, which makes chain updates atomic.

---
 rtl/data_table_dispatcher_if.sv | 109 ++++++++++
 rtl/data_table_dispatcher.sv | 173 +++++++++++++++++
 tb/tb_data_table_dispatcher.sv | 507 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_table_dispatcher_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_table_dispatcher_if : task, engine, data-RAM and result bus of the   |
// |                            data table dispatcher, with shared types.      |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+

package data_table_dispatcher_pkg;

  localparam int TABLE_ADDR_WIDTH = 8;

  localparam logic [1:0] OP_SEARCH = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;

  typedef struct packed {
    logic [1:0] opcode;
    logic [5:0] flags;
  } ht_cmd_t;

  typedef struct packed {
    ht_cmd_t     cmd;
    logic [31:0] key;
    logic [31:0] value;
  } ht_pdata_t;

  typedef struct packed {
    logic [1:0]  status;
    logic [31:0] value;
    logic [7:0]  chain_len;
  } ht_result_t;

  typedef logic [63:0] ram_data_t;

endpackage

interface data_table_dispatcher_if #(
  parameter int A_WIDTH = data_table_dispatcher_pkg::TABLE_ADDR_WIDTH,
  parameter int ENG_CNT = 3
) ();
  import data_table_dispatcher_pkg::*;

  // Upstream task channel
  ht_pdata_t                       task_i;
  logic                            task_valid_i;
  logic                            task_ready_o;

  // Task broadcast to the engines
  ht_pdata_t                       eng_task_o;
  logic [ENG_CNT-1:0]              eng_task_valid_o;
  logic [ENG_CNT-1:0]              eng_task_ready_i;

  // Per-engine data-RAM requests
  logic [ENG_CNT-1:0][A_WIDTH-1:0] eng_rd_addr_i;
  logic [ENG_CNT-1:0]              eng_rd_en_i;
  logic [ENG_CNT-1:0][A_WIDTH-1:0] eng_wr_addr_i;
  ram_data_t [ENG_CNT-1:0]         eng_wr_data_i;
  logic [ENG_CNT-1:0]              eng_wr_en_i;

  // Single data-RAM port pair
  logic [A_WIDTH-1:0]              rd_addr_o;
  logic                            rd_en_o;
  logic [A_WIDTH-1:0]              wr_addr_o;
  ram_data_t                       wr_data_o;
  logic                            wr_en_o;

  // Engine results and upstream result channel
  ht_result_t [ENG_CNT-1:0]        eng_result_i;
  logic [ENG_CNT-1:0]              eng_result_valid_i;
  logic [ENG_CNT-1:0]              eng_result_ready_o;
  ht_result_t                      result_o;
  logic                            result_valid_o;
  logic                            result_ready_i;

  // Status
  logic                            bad_opcode_o;
  logic                            wdog_err_o;

  modport slave (
    input  task_i, task_valid_i,
    output task_ready_o,
    output eng_task_o, eng_task_valid_o,
    input  eng_task_ready_i,
    input  eng_rd_addr_i, eng_rd_en_i, eng_wr_addr_i, eng_wr_data_i, eng_wr_en_i,
    output rd_addr_o, rd_en_o, wr_addr_o, wr_data_o, wr_en_o,
    input  eng_result_i, eng_result_valid_i,
    output eng_result_ready_o,
    output result_o, result_valid_o,
    input  result_ready_i,
    output bad_opcode_o, wdog_err_o
  );

  modport master (
    output task_i, task_valid_i,
    input  task_ready_o,
    input  eng_task_o, eng_task_valid_o,
    output eng_task_ready_i,
    output eng_rd_addr_i, eng_rd_en_i, eng_wr_addr_i, eng_wr_data_i, eng_wr_en_i,
    input  rd_addr_o, rd_en_o, wr_addr_o, wr_data_o, wr_en_o,
    output eng_result_i, eng_result_valid_i,
    input  eng_result_ready_o,
    input  result_o, result_valid_o,
    output result_ready_i,
    input  bad_opcode_o, wdog_err_o
  );

endinterface

`default_nettype wire

// File: rtl/data_table_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_table_dispatcher : routes one hash-table task at a time to the      |
// |   search/insert/delete engine and lends it the data-RAM port pair.        |
// | Optional watchdog: define DATA_TABLE_DISPATCHER_WDOG_EN.                  |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+

module data_table_dispatcher
  import data_table_dispatcher_pkg::*;
#(
  parameter int A_WIDTH     = TABLE_ADDR_WIDTH,
  parameter int ENG_CNT     = 3,
  parameter int WDOG_CYCLES = 1024
) (
  input logic                    clk_i,
  input logic                    rst_i,
  data_table_dispatcher_if.slave bus
);

  localparam int                 c_OWN_W = $clog2(ENG_CNT);
  localparam logic [ENG_CNT-1:0] c_ONE   = ENG_CNT'(1);

  typedef enum logic [1:0] {
    IDLE_S     = 2'd0,
    DISPATCH_S = 2'd1,
    BUSY_S     = 2'd2
  } state_t;

  state_t             r_state;
  logic [c_OWN_W-1:0] r_owner;
  logic               r_task_ready;
  ht_pdata_t          r_eng_task;
  logic [ENG_CNT-1:0] r_eng_task_valid;
  logic               r_bad_opcode;

  logic               w_dec_known;
  logic [c_OWN_W-1:0] w_dec_owner;
  logic               w_accept;
  logic               w_busy;
  logic               w_dispatch_hs;
  logic               w_result_hs;
  logic [ENG_CNT-1:0] w_owner_vec;
  logic [A_WIDTH-1:0] w_rd_addr;
  logic [A_WIDTH-1:0] w_wr_addr;
  ram_data_t          w_wr_data;

  always_comb begin
    w_dec_known = 1'b1;
    w_dec_owner = '0;
    unique case (bus.task_i.cmd.opcode)
      OP_SEARCH: w_dec_owner = c_OWN_W'(0);
      OP_INSERT: w_dec_owner = c_OWN_W'(1);
      OP_DELETE: w_dec_owner = c_OWN_W'(2);
      default:   w_dec_known = 1'b0;
    endcase
  end

  assign w_accept      = bus.task_valid_i && r_task_ready && (r_state == IDLE_S);
  assign w_owner_vec   = c_ONE << r_owner;
  // Combinational outputs are forced quiet during reset, not just after it.
  assign w_busy        = (r_state == BUSY_S) && !rst_i;
  assign w_dispatch_hs = r_eng_task_valid[r_owner] && bus.eng_task_ready_i[r_owner];
  assign w_result_hs   = w_busy && bus.eng_result_valid_i[r_owner] && bus.result_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= IDLE_S;
      r_owner          <= '0;
      r_task_ready     <= 1'b1;
      r_eng_task       <= '0;
      r_eng_task_valid <= '0;
      r_bad_opcode     <= 1'b0;
    end else begin
      r_bad_opcode <= 1'b0;
      unique case (r_state)
        IDLE_S: begin
          r_task_ready <= 1'b1;
          if (w_accept) begin
            r_eng_task <= bus.task_i;
            if (w_dec_known) begin
              r_owner          <= w_dec_owner;
              r_eng_task_valid <= c_ONE << w_dec_owner;
              r_task_ready     <= 1'b0;
              r_state          <= DISPATCH_S;
            end else begin
              r_bad_opcode <= 1'b1;
            end
          end
        end
        DISPATCH_S: begin
          if (w_dispatch_hs) begin
            r_eng_task_valid <= '0;
            r_state          <= BUSY_S;
          end
        end
        BUSY_S: begin
          if (w_result_hs) begin
            r_task_ready <= 1'b1;
            r_state      <= IDLE_S;
          end
        end
        default: begin
          r_state          <= IDLE_S;
          r_task_ready     <= 1'b1;
          r_eng_task_valid <= '0;
        end
      endcase
    end
  end

  // The owner's RAM port group is passed straight through while busy.
  always_comb begin
    w_rd_addr = bus.eng_rd_addr_i[r_owner];
    w_wr_addr = bus.eng_wr_addr_i[r_owner];
    w_wr_data = bus.eng_wr_data_i[r_owner];
  end

  assign bus.rd_addr_o          = w_rd_addr;
  assign bus.rd_en_o            = w_busy & bus.eng_rd_en_i[r_owner];
  assign bus.wr_addr_o          = w_wr_addr;
  assign bus.wr_data_o          = w_wr_data;
  assign bus.wr_en_o            = w_busy & bus.eng_wr_en_i[r_owner];

  assign bus.result_o           = bus.eng_result_i[r_owner];
  assign bus.result_valid_o     = w_busy & bus.eng_result_valid_i[r_owner];
  assign bus.eng_result_ready_o = (w_busy && bus.result_ready_i) ? w_owner_vec : '0;

  assign bus.task_ready_o       = r_task_ready;
  assign bus.eng_task_o         = r_eng_task;
  assign bus.eng_task_valid_o   = rst_i ? '0 : r_eng_task_valid;
  assign bus.bad_opcode_o       = r_bad_opcode & ~rst_i;

`ifdef DATA_TABLE_DISPATCHER_WDOG_EN
  localparam int               c_WDOG_W   = $clog2(WDOG_CYCLES + 1);
  localparam logic [c_WDOG_W-1:0] c_WDOG_MAX = c_WDOG_W'(WDOG_CYCLES);

  logic [c_WDOG_W-1:0] r_wdog_cnt;
  logic                r_wdog_err;

  // Only flags a stuck task; the FSM is left where it is.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if (r_state == IDLE_S) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != c_WDOG_MAX) begin
        r_wdog_cnt <= r_wdog_cnt + c_WDOG_W'(1);
      end
      if (r_wdog_cnt == c_WDOG_MAX) begin
        r_wdog_err <= 1'b1;
      end
    end
  end

  assign bus.wdog_err_o = r_wdog_err;
`else
  logic w_unused_wdog;
  assign w_unused_wdog  = ^WDOG_CYCLES;
  assign bus.wdog_err_o = 1'b0;
`endif

`ifndef SYNTHESIS
  a_nonowner_ram_en : assert property (@(posedge clk_i) disable iff (rst_i)
      (r_state == BUSY_S) |-> (((bus.eng_rd_en_i | bus.eng_wr_en_i) & ~w_owner_vec) == '0))
    else $warning("data_table_dispatcher: non-owner engine drove a RAM enable");
`endif

endmodule

`default_nettype wire

// File: tb/tb_data_table_dispatcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_table_dispatcher : randomized self-checking bench for            |
// |   data_table_dispatcher against an opcode->engine routing model.         |
// | Revision : 1.0                                                            |
// +--------------------------------------------------------------------------+

module tb_data_table_dispatcher;
  import data_table_dispatcher_pkg::*;

  localparam int AW = TABLE_ADDR_WIDTH;
  localparam int EC = 3;
  localparam int WD = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_table_dispatcher_if #(.A_WIDTH(AW), .ENG_CNT(EC)) bus ();

  data_table_dispatcher #(
    .A_WIDTH    (AW),
    .ENG_CNT    (EC),
    .WDOG_CYCLES(WD)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  // Reference routing: search/insert/delete go to engines 0/1/2, others are dropped.
  function automatic int engine_for(input logic [1:0] op);
    if (op == 2'd0) return 0;
    if (op == 2'd1) return 1;
    if (op == 2'd2) return 2;
    return -1;
  endfunction

  function automatic ht_pdata_t rand_task(input logic [1:0] op);
    ht_pdata_t t;
    t.cmd.opcode = op;
    t.cmd.flags  = 6'($urandom);
    t.key        = $urandom;
    t.value      = $urandom;
    return t;
  endfunction

  function automatic ht_result_t rand_result();
    ht_result_t r;
    r.status    = 2'($urandom);
    r.value     = $urandom;
    r.chain_len = 8'($urandom);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.task_i             = '0;
    bus.task_valid_i       = 1'b0;
    bus.eng_task_ready_i   = '0;
    bus.eng_rd_addr_i      = '0;
    bus.eng_rd_en_i        = '0;
    bus.eng_wr_addr_i      = '0;
    bus.eng_wr_data_i      = '0;
    bus.eng_wr_en_i        = '0;
    bus.eng_result_i       = '0;
    bus.eng_result_valid_i = '0;
    bus.result_ready_i     = 1'b0;
  endtask

  // Completes an in-flight task on engine e with an immediate handshake.
  task automatic drain(input int e);
    bus.eng_task_ready_i   = 3'(1 << e);
    tick();
    bus.eng_task_ready_i   = '0;
    bus.eng_result_valid_i = 3'(1 << e);
    bus.result_ready_i     = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.eng_rd_en_i        = '1;
    bus.eng_wr_en_i        = '1;
    bus.eng_result_valid_i = '1;
    bus.result_ready_i     = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.task_ready_o !== 1'b1 || bus.eng_task_valid_o !== 3'b000 || bus.bad_opcode_o !== 1'b0
        || bus.wdog_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs got ready=%b tv=%b bad=%b wdog=%b exp 1 000 0 0",
               bus.task_ready_o, bus.eng_task_valid_o, bus.bad_opcode_o, bus.wdog_err_o);
    end
    checks++;
    if (bus.rd_en_o !== 1'b0 || bus.wr_en_o !== 1'b0 || bus.result_valid_o !== 1'b0
        || bus.eng_result_ready_o !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got rd=%b wr=%b rv=%b err=%b exp 0 0 0 000",
               bus.rd_en_o, bus.wr_en_o, bus.result_valid_o, bus.eng_result_ready_o);
    end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  task automatic test_search_dispatch();
    ht_pdata_t  t;
    ht_result_t r;
    t = rand_task(OP_SEARCH);
    r = rand_result();
    bus.eng_task_ready_i = 3'b111;
    bus.task_i           = t;
    bus.task_valid_i     = 1'b1;
    tick();
    bus.task_valid_i = 1'b0;
    checks++;
    if (bus.eng_task_valid_o !== 3'b001 || bus.eng_task_o !== t || bus.task_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL search_dispatch got tv=%b task=%h rdy=%b exp 001 %h 0",
               bus.eng_task_valid_o, bus.eng_task_o, bus.task_ready_o, t);
    end
    tick();
    bus.eng_task_ready_i = '0;
    checks++;
    if (bus.eng_task_valid_o !== 3'b000) begin
      errors++;
      $display("FAIL search_valid_width got %b exp 000", bus.eng_task_valid_o);
    end
    repeat (3) begin
      checks++;
      if (bus.result_valid_o !== 1'b0 || bus.task_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL search_wait got rv=%b rdy=%b exp 0 0", bus.result_valid_o, bus.task_ready_o);
      end
      tick();
    end
    bus.eng_result_i[0]    = r;
    bus.eng_result_i[1]    = rand_result();
    bus.eng_result_valid_i = 3'b011;
    bus.result_ready_i     = 1'b1;
    #1;
    checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_o !== r || bus.eng_result_ready_o !== 3'b001) begin
      errors++;
      $display("FAIL search_result got rv=%b res=%h err=%b exp 1 %h 001",
               bus.result_valid_o, bus.result_o, bus.eng_result_ready_o, r);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.task_ready_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL search_return_idle got rdy=%b rv=%b exp 1 0", bus.task_ready_o, bus.result_valid_o);
    end
  endtask

  task automatic test_random();
    ht_pdata_t          t;
    ht_result_t         r;
    ht_result_t         exp_q[$];
    int                 eng;
    logic [2:0]         vec;
    logic [AW-1:0]      ra;
    logic [AW-1:0]      wa;
    ram_data_t          wd;
    logic               re;
    logic               we;
    for (int n = 0; n < 24; n++) begin
      t   = rand_task(2'($urandom_range(0, 3)));
      eng = engine_for(t.cmd.opcode);
      vec = (eng < 0) ? 3'b000 : 3'(1 << eng);
      bus.task_i       = t;
      bus.task_valid_i = 1'b1;
      tick();
      bus.task_valid_i = 1'b0;
      checks++;
      if (bus.eng_task_valid_o !== vec) begin
        errors++;
        $display("FAIL rand_route n=%0d op=%0d got %b exp %b", n, t.cmd.opcode, bus.eng_task_valid_o, vec);
      end
      if (eng < 0) begin
        checks++;
        if (bus.bad_opcode_o !== 1'b1 || bus.task_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL rand_bad n=%0d got bad=%b rdy=%b exp 1 1", n, bus.bad_opcode_o, bus.task_ready_o);
        end
        tick();
        checks++;
        if (bus.bad_opcode_o !== 1'b0) begin
          errors++;
          $display("FAIL rand_bad_pulse n=%0d got %b exp 0", n, bus.bad_opcode_o);
        end
        continue;
      end
      checks++;
      if (bus.eng_task_o !== t) begin
        errors++;
        $display("FAIL rand_task_copy n=%0d got %h exp %h", n, bus.eng_task_o, t);
      end
      repeat ($urandom_range(0, 3)) tick();
      checks++;
      if (bus.eng_task_valid_o !== vec || bus.task_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_hold n=%0d got tv=%b rdy=%b exp %b 0", n, bus.eng_task_valid_o, bus.task_ready_o, vec);
      end
      bus.eng_task_ready_i = vec;
      tick();
      bus.eng_task_ready_i = '0;
      checks++;
      if (bus.eng_task_valid_o !== 3'b000) begin
        errors++;
        $display("FAIL rand_dispatch_drop n=%0d got %b exp 000", n, bus.eng_task_valid_o);
      end
      repeat ($urandom_range(0, 2)) tick();
      ra = AW'($urandom);
      wa = AW'($urandom);
      wd = {$urandom, $urandom};
      re = 1'($urandom);
      we = 1'($urandom);
      for (int i = 0; i < EC; i++) begin
        bus.eng_rd_addr_i[i] = AW'($urandom);
        bus.eng_wr_addr_i[i] = AW'($urandom);
        bus.eng_wr_data_i[i] = {$urandom, $urandom};
        bus.eng_result_i[i]  = rand_result();
      end
      bus.eng_rd_addr_i[eng] = ra;
      bus.eng_wr_addr_i[eng] = wa;
      bus.eng_wr_data_i[eng] = wd;
      bus.eng_rd_en_i        = re ? vec : 3'b000;
      bus.eng_wr_en_i        = we ? vec : 3'b000;
      #1;
      checks++;
      if (bus.rd_en_o !== re || bus.wr_en_o !== we || (re && bus.rd_addr_o !== ra)
          || (we && (bus.wr_addr_o !== wa || bus.wr_data_o !== wd))) begin
        errors++;
        $display("FAIL rand_ram n=%0d got rd=%b@%h wr=%b@%h:%h exp %b@%h %b@%h:%h", n,
                 bus.rd_en_o, bus.rd_addr_o, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, re, ra, we, wa, wd);
      end
      r = rand_result();
      exp_q.push_back(r);
      bus.eng_result_i[eng]  = r;
      bus.eng_result_valid_i = vec | 3'($urandom);
      bus.result_ready_i     = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        #1;
        checks++;
        if (bus.result_valid_o !== 1'b1 || bus.result_o !== exp_q[0] || bus.eng_result_ready_o !== 3'b000) begin
          errors++;
          $display("FAIL rand_result_stall n=%0d got rv=%b res=%h err=%b exp 1 %h 000", n,
                   bus.result_valid_o, bus.result_o, bus.eng_result_ready_o, exp_q[0]);
        end
        tick();
      end
      bus.result_ready_i = 1'b1;
      #1;
      checks++;
      if (bus.result_valid_o !== 1'b1 || bus.result_o !== exp_q[0] || bus.eng_result_ready_o !== vec) begin
        errors++;
        $display("FAIL rand_result n=%0d got rv=%b res=%h err=%b exp 1 %h %b", n,
                 bus.result_valid_o, bus.result_o, bus.eng_result_ready_o, exp_q[0], vec);
      end
      void'(exp_q.pop_front());
      tick();
      idle_inputs();
      checks++;
      if (bus.task_ready_o !== 1'b1 || bus.result_valid_o !== 1'b0) begin
        errors++;
        $display("FAIL rand_idle n=%0d got rdy=%b rv=%b exp 1 0", n, bus.task_ready_o, bus.result_valid_o);
      end
    end
  endtask

  task automatic test_ram_mux();
    ht_result_t r;
    ram_data_t  wd;
    r  = rand_result();
    wd = {$urandom, $urandom};
    bus.task_i       = rand_task(OP_DELETE);
    bus.task_valid_i = 1'b1;
    tick();
    bus.task_valid_i     = 1'b0;
    bus.eng_task_ready_i = 3'b100;
    tick();
    bus.eng_task_ready_i   = '0;
    bus.eng_rd_en_i        = 3'b010;
    bus.eng_rd_addr_i[1]   = AW'(8'h05);
    bus.eng_rd_addr_i[2]   = AW'(8'h33);
    bus.eng_wr_en_i        = 3'b100;
    bus.eng_wr_addr_i[2]   = AW'(8'h1A);
    bus.eng_wr_data_i[2]   = wd;
    bus.eng_result_i[2]    = r;
    bus.eng_result_valid_i = 3'b100;
    bus.result_ready_i     = 1'b1;
    #1;
    checks++;
    if (bus.rd_en_o !== 1'b0 || bus.wr_en_o !== 1'b1 || bus.wr_addr_o !== AW'(8'h1A) || bus.wr_data_o !== wd) begin
      errors++;
      $display("FAIL ram_mux_isolation got rd=%b wr=%b wa=%h wd=%h exp 0 1 1a %h",
               bus.rd_en_o, bus.wr_en_o, bus.wr_addr_o, bus.wr_data_o, wd);
    end
    checks++;
    if (bus.result_valid_o !== 1'b1 || bus.result_o !== r || bus.eng_result_ready_o !== 3'b100) begin
      errors++;
      $display("FAIL ram_mux_result_with_write got rv=%b res=%h err=%b exp 1 %h 100",
               bus.result_valid_o, bus.result_o, bus.eng_result_ready_o, r);
    end
    bus.eng_rd_en_i = '0;
    tick();
    idle_inputs();
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.task_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ram_mux_after got wr=%b rdy=%b exp 0 1", bus.wr_en_o, bus.task_ready_o);
    end
  endtask

  task automatic test_back_pressure();
    ht_result_t r;
    int         cnt;
    r = rand_result();
    bus.task_i       = rand_task(OP_INSERT);
    bus.task_valid_i = 1'b1;
    tick();
    bus.task_i = rand_task(2'd3);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) bus.eng_task_ready_i = 3'b010;
      #1;
      if (bus.eng_task_valid_o == 3'b010) cnt++;
      checks++;
      if (bus.task_ready_o !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_dispatch i=%0d got rdy=%b exp 0", i, bus.task_ready_o);
      end
      tick();
    end
    bus.eng_task_ready_i = '0;
    checks++;
    if (cnt != 6 || bus.eng_task_valid_o !== 3'b000) begin
      errors++;
      $display("FAIL bp_valid_hold got %0d cycles tv=%b exp 6 000", cnt, bus.eng_task_valid_o);
    end
    bus.eng_result_i[1]    = r;
    bus.eng_result_valid_i = 3'b010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.result_valid_o !== 1'b1 || bus.result_o !== r || bus.task_ready_o !== 1'b0
          || bus.eng_result_ready_o !== 3'b000) begin
        errors++;
        $display("FAIL bp_result_hold i=%0d got rv=%b res=%h rdy=%b err=%b exp 1 %h 0 000", i,
                 bus.result_valid_o, bus.result_o, bus.task_ready_o, bus.eng_result_ready_o, r);
      end
      tick();
    end
    bus.result_ready_i = 1'b1;
    tick();
    bus.result_ready_i     = 1'b0;
    bus.eng_result_valid_i = '0;
    checks++;
    if (bus.task_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready_return got %b exp 1", bus.task_ready_o);
    end
    tick();
    bus.task_valid_i = 1'b0;
    checks++;
    if (bus.bad_opcode_o !== 1'b1 || bus.eng_task_valid_o !== 3'b000) begin
      errors++;
      $display("FAIL bp_second_accept got bad=%b tv=%b exp 1 000", bus.bad_opcode_o, bus.eng_task_valid_o);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_bad_opcode();
    ht_pdata_t t;
    bus.task_i       = rand_task(2'd3);
    bus.task_valid_i = 1'b1;
    tick();
    checks++;
    if (bus.bad_opcode_o !== 1'b1 || bus.eng_task_valid_o !== 3'b000 || bus.task_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bad_op_pulse got bad=%b tv=%b rdy=%b exp 1 000 1",
               bus.bad_opcode_o, bus.eng_task_valid_o, bus.task_ready_o);
    end
    t = rand_task(OP_INSERT);
    bus.task_i = t;
    tick();
    bus.task_valid_i = 1'b0;
    checks++;
    if (bus.bad_opcode_o !== 1'b0 || bus.eng_task_valid_o !== 3'b010 || bus.eng_task_o !== t) begin
      errors++;
      $display("FAIL bad_op_next_task got bad=%b tv=%b task=%h exp 0 010 %h",
               bus.bad_opcode_o, bus.eng_task_valid_o, bus.eng_task_o, t);
    end
    drain(1);
  endtask

  task automatic test_reset_mid_op();
    bus.task_i       = rand_task(OP_INSERT);
    bus.task_valid_i = 1'b1;
    tick();
    bus.task_valid_i     = 1'b0;
    bus.eng_task_ready_i = 3'b010;
    tick();
    bus.eng_task_ready_i   = '0;
    bus.eng_wr_en_i        = 3'b010;
    bus.eng_rd_en_i        = 3'b010;
    bus.eng_result_valid_i = 3'b010;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b1 || bus.rd_en_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_busy got wr=%b rd=%b exp 1 1", bus.wr_en_o, bus.rd_en_o);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.rd_en_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_during got wr=%b rd=%b rv=%b exp 0 0 0", bus.wr_en_o, bus.rd_en_o, bus.result_valid_o);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.wr_en_o !== 1'b0 || bus.rd_en_o !== 1'b0 || bus.result_valid_o !== 1'b0
        || bus.task_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_after got wr=%b rd=%b rv=%b rdy=%b exp 0 0 0 1",
               bus.wr_en_o, bus.rd_en_o, bus.result_valid_o, bus.task_ready_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wdog();
    int first;
    first = 0;
    bus.task_i           = rand_task(OP_SEARCH);
    bus.task_valid_i     = 1'b1;
    bus.eng_task_ready_i = 3'b001;
    tick();
    bus.task_valid_i = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k == 2) bus.eng_task_ready_i = '0;
      if (first == 0 && bus.wdog_err_o === 1'b1) first = k;
    end
`ifdef DATA_TABLE_DISPATCHER_WDOG_EN
    checks++;
    if (first < WD || first > WD + 1) begin
      errors++;
      $display("FAIL wdog_rise got cycle %0d exp %0d..%0d", first, WD, WD + 1);
    end
    repeat (5) tick();
    checks++;
    if (bus.wdog_err_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog_sticky got %b exp 1", bus.wdog_err_o);
    end
`else
    checks++;
    if (first != 0 || bus.wdog_err_o !== 1'b0) begin
      errors++;
      $display("FAIL wdog_disabled got rise at %0d now %b exp never 0", first, bus.wdog_err_o);
    end
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (bus.wdog_err_o !== 1'b0 || bus.task_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL wdog_clear got err=%b rdy=%b exp 0 1", bus.wdog_err_o, bus.task_ready_o);
    end
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_search_dispatch();
    test_random();
    test_ram_mux();
    test_back_pressure();
    test_bad_opcode();
    test_reset_mid_op();
    test_wdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
